// File: rtl/counter_link_pkg.sv
// Shared constants and types for the counter host link: command bytes, packet
// headers and the transmit FSM state encoding.
package counter_link_pkg;

  localparam logic [7:0] CMD_ACK1  = 8'h00;
  localparam logic [7:0] CMD_ACK2  = 8'h01;
  localparam logic [7:0] CMD_TRIG1 = 8'h02;
  localparam logic [7:0] CMD_TRIG2 = 8'h03;

  localparam logic [7:0] HDR_REG1 = 8'h00;
  localparam logic [7:0] HDR_REG2 = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA
  } tx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser for bringing an asynchronous level
// into the local clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking (<=) so both flops sample the
  // pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/counter_link.sv
// Host-side link engine: frames latched counter values into byte packets and
// turns host command bytes into latch-reset and test-latch strobes.
module counter_link
  import counter_link_pkg::*;
#(
  parameter int pBYTES = 5,
  parameter int pPULSE = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iRdy1,
  input  logic [31:0] i1Counter,
  input  logic [31:0] i1CounterHi,
  input  logic        iRdy2,
  input  logic [31:0] i2Counter,
  input  logic [31:0] i2CounterHi,
  output logic        oResetLatch1,
  output logic        oResetLatch2,
  output logic        oLatch1,
  output logic        oLatch2,
  output logic [7:0]  oTxData,
  output logic        oTxValid,
  input  logic        iTxReady,
  input  logic [7:0]  iRxData,
  input  logic        iRxValid,
  output logic        oBadCmd,
  output logic        oBusy
);

  logic        rdy1_s, rdy2_s;
  logic        sent1, sent2;
  tx_state_t   state, next_state;
  logic [63:0] shift;
  logic [3:0]  count;
  logic        sel_reg2;
  logic        load1, load2, last_byte;
  logic [7:0]  pulse1, pulse2;

  sync_2ff u_sync1 (.clk(iCLK), .rst(iRST), .d(iRdy1), .q(rdy1_s));
  sync_2ff u_sync2 (.clk(iCLK), .rst(iRST), .d(iRdy2), .q(rdy2_s));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Valid and data depend only on registered state, so they cannot change
  // while a byte is stalled waiting for iTxReady.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    next_state = state;
    load1      = 1'b0;
    load2      = 1'b0;
    last_byte  = 1'b0;
    oTxValid   = 1'b0;
    oTxData    = 8'h00;
    case (state)
      ST_IDLE: begin
        if (rdy1_s && !sent1) begin
          load1      = 1'b1;
          next_state = ST_HDR;
        end else if (rdy2_s && !sent2) begin
          load2      = 1'b1;
          next_state = ST_HDR;
        end
      end
      ST_HDR: begin
        oTxValid = 1'b1;
        oTxData  = sel_reg2 ? HDR_REG2 : HDR_REG1;
        if (iTxReady) next_state = ST_DATA;
      end
      ST_DATA: begin
        oTxValid = 1'b1;
        oTxData  = shift[7:0];
        if (iTxReady && count == 4'd1) begin
          last_byte  = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign oBusy = (state != ST_IDLE);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      shift    <= '0;
      count    <= '0;
      sel_reg2 <= 1'b0;
      sent1    <= 1'b0;
      sent2    <= 1'b0;
    end else begin
      if (load1) begin
        shift    <= {i1CounterHi, i1Counter};
        count    <= 4'(pBYTES);
        sel_reg2 <= 1'b0;
      end else if (load2) begin
        shift    <= {i2CounterHi, i2Counter};
        count    <= 4'(pBYTES);
        sel_reg2 <= 1'b1;
      end else if (state == ST_DATA && iTxReady) begin
        shift <= {8'h00, shift[63:8]};
        count <= count - 4'd1;
      end
      // Completion wins over a dropped ready so the flag clears one cycle later.
      if (last_byte && !sel_reg2) sent1 <= 1'b1;
      else if (!rdy1_s)           sent1 <= 1'b0;
      if (last_byte && sel_reg2)  sent2 <= 1'b1;
      else if (!rdy2_s)           sent2 <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oResetLatch1 <= 1'b0;
      oResetLatch2 <= 1'b0;
      oBadCmd      <= 1'b0;
      pulse1       <= '0;
      pulse2       <= '0;
    end else begin
      oResetLatch1 <= iRxValid && (iRxData == CMD_ACK1);
      oResetLatch2 <= iRxValid && (iRxData == CMD_ACK2);
      oBadCmd      <= iRxValid && (iRxData > CMD_TRIG2);
      if (iRxValid && iRxData == CMD_TRIG1) pulse1 <= 8'(pPULSE);
      else if (pulse1 != 8'd0)              pulse1 <= pulse1 - 8'd1;
      if (iRxValid && iRxData == CMD_TRIG2) pulse2 <= 8'(pPULSE);
      else if (pulse2 != 8'd0)              pulse2 <= pulse2 - 8'd1;
    end
  end

  assign oLatch1 = (pulse1 != 8'd0);
  assign oLatch2 = (pulse2 != 8'd0);

endmodule

// File: tb/tb_counter_link.sv
// Self-checking bench for counter_link: a packet/command model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_counter_link;
  import counter_link_pkg::*;

  localparam int P_BYTES = 5;
  localparam int P_PULSE = 4;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iRdy1 = 1'b0, iRdy2 = 1'b0;
  logic [31:0] i1Counter = '0, i1CounterHi = '0;
  logic [31:0] i2Counter = '0, i2CounterHi = '0;
  logic        oResetLatch1, oResetLatch2, oLatch1, oLatch2;
  logic [7:0]  oTxData;
  logic        oTxValid;
  logic        iTxReady = 1'b0;
  logic [7:0]  iRxData = '0;
  logic        iRxValid = 1'b0;
  logic        oBadCmd, oBusy;

  counter_link #(.pBYTES(P_BYTES), .pPULSE(P_PULSE)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iRdy1(iRdy1), .i1Counter(i1Counter), .i1CounterHi(i1CounterHi),
    .iRdy2(iRdy2), .i2Counter(i2Counter), .i2CounterHi(i2CounterHi),
    .oResetLatch1(oResetLatch1), .oResetLatch2(oResetLatch2),
    .oLatch1(oLatch1), .oLatch2(oLatch2),
    .oTxData(oTxData), .oTxValid(oTxValid), .iTxReady(iTxReady),
    .iRxData(iRxData), .iRxValid(iRxValid),
    .oBadCmd(oBadCmd), .oBusy(oBusy)
  );

  always #5 iCLK = ~iCLK;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always @(posedge iCLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else pass_cnt++;
  endtask

  // Expected transmit stream and the log of bytes actually transferred.
  logic [7:0] exp_q[$];
  logic [7:0] log_b[$];
  int         log_c[$];

  task automatic push_packet(input logic [7:0] hdr, input logic [63:0] val);
    exp_q.push_back(hdr);
    for (int i = 0; i < P_BYTES; i++) exp_q.push_back(val[8*i +: 8]);
  endtask

  // Command model: history of the previous receive strobe and the cycle of the
  // most recent trigger for each register.
  bit         prev_rx_v  = 1'b0;
  logic [7:0] prev_rx_d  = '0;
  int         last_t1    = -1000;
  int         last_t2    = -1000;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  always @(negedge iCLK) begin
    if (iRST) begin
      prev_rx_v  = 1'b0;
      last_t1    = -1000;
      last_t2    = -1000;
      prev_stall = 1'b0;
    end else begin
      check("ack1", 64'(oResetLatch1), 64'(prev_rx_v && prev_rx_d == CMD_ACK1));
      check("ack2", 64'(oResetLatch2), 64'(prev_rx_v && prev_rx_d == CMD_ACK2));
      check("badcmd", 64'(oBadCmd), 64'(prev_rx_v && prev_rx_d > CMD_TRIG2));
      check("latch1", 64'(oLatch1), 64'((cyc - last_t1) >= 1 && (cyc - last_t1) <= P_PULSE));
      check("latch2", 64'(oLatch2), 64'((cyc - last_t2) >= 1 && (cyc - last_t2) <= P_PULSE));
      check("busy", 64'(oBusy), 64'(oTxValid));
      if (prev_stall) begin
        check("stall_valid", 64'(oTxValid), 64'd1);
        check("stall_data", 64'(oTxData), 64'(prev_data));
      end
      if (oTxValid && iTxReady) begin
        check("tx_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("tx_byte", 64'(oTxData), 64'(exp_q.pop_front()));
        log_b.push_back(oTxData);
        log_c.push_back(cyc);
      end
      prev_stall = oTxValid && !iTxReady;
      prev_data  = oTxData;
      prev_rx_v  = iRxValid;
      prev_rx_d  = iRxData;
      if (iRxValid && iRxData == CMD_TRIG1) last_t1 = cyc;
      if (iRxValid && iRxData == CMD_TRIG2) last_t2 = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic wait_tx_done(input string name, input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick(1);
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_rx(input logic [7:0] b);
    iRxValid = 1'b1;
    iRxData  = b;
    tick(1);
    iRxValid = 1'b0;
  endtask

  function automatic int sample(input int sel);
    case (sel)
      0:       return int'(oResetLatch1);
      1:       return int'(oResetLatch2);
      2:       return int'(oLatch1);
      3:       return int'(oLatch2);
      default: return int'(oBadCmd);
    endcase
  endfunction

  logic [7:0] rx_cmd[5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07};
  int         rx_sel[5] = '{0, 1, 2, 3, 4};
  int         rx_len[5] = '{1, 1, 4, 4, 1};
  logic [7:0] pkt1[6]   = '{8'h00, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};

  initial begin
    int h;

    // Reset state
    tick(3);
    check("rst_txvalid", 64'(oTxValid), 64'd0);
    check("rst_txdata", 64'(oTxData), 64'd0);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_latch1", 64'(oLatch1), 64'd0);
    check("rst_ack1", 64'(oResetLatch1), 64'd0);
    check("rst_bad", 64'(oBadCmd), 64'd0);
    iRST = 1'b0;
    iTxReady = 1'b1;
    tick(3);

    // Single packet, no repeat while ready stays high
    {i1CounterHi, i1Counter} = 64'h0000_0012_3456_789A;
    push_packet(HDR_REG1, 64'h0000_0012_3456_789A);
    log_b.delete(); log_c.delete();
    iRdy1 = 1'b1;
    wait_tx_done("pkt1_done", 50);
    tick(20);
    check("pkt1_len", 64'(log_b.size()), 64'd6);
    for (int i = 0; i < 6 && i < log_b.size(); i++) check("pkt1_lit", 64'(log_b[i]), 64'(pkt1[i]));
    if (log_c.size() == 6) check("pkt1_back2back", 64'(log_c[5] - log_c[0]), 64'd5);
    iRdy1 = 1'b0;
    tick(5);

    // Both ready together: register 1 first, then register 2
    {i1CounterHi, i1Counter} = 64'h0000_0000_CAFE_F00D;
    {i2CounterHi, i2Counter} = 64'h0000_0000_0000_0055;
    push_packet(HDR_REG1, 64'h0000_0000_CAFE_F00D);
    push_packet(HDR_REG2, 64'h0000_0000_0000_0055);
    log_b.delete(); log_c.delete();
    iRdy1 = 1'b1; iRdy2 = 1'b1;
    wait_tx_done("pkt12_done", 80);
    tick(10);
    check("pkt12_len", 64'(log_b.size()), 64'd12);
    if (log_b.size() >= 8) begin
      check("pkt12_hdr1", 64'(log_b[0]), 64'h00);
      check("pkt12_hdr2", 64'(log_b[6]), 64'h01);
      check("pkt12_b55", 64'(log_b[7]), 64'h55);
    end
    iRdy1 = 1'b0; iRdy2 = 1'b0;
    tick(5);

    // Backpressure 1-0-0-1 during a register 2 packet
    {i2CounterHi, i2Counter} = 64'hA1B2_C3D4_E5F6_0718;
    push_packet(HDR_REG2, 64'hA1B2_C3D4_E5F6_0718);
    log_b.delete(); log_c.delete();
    iRdy2 = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      iTxReady = (i % 4 == 0) || (i % 4 == 3);
      tick(1);
    end
    check("stall_done", 64'(exp_q.size()), 64'd0);
    iTxReady = 1'b1;
    if (log_b.size() >= 2) check("stall_b1", 64'(log_b[1]), 64'h18);
    iRdy2 = 1'b0;
    tick(5);

    // Command decode: strobe lengths on isolated commands
    for (int k = 0; k < 5; k++) begin
      send_rx(rx_cmd[k]);
      h = 0;
      for (int j = 0; j < 10; j++) begin
        h += sample(rx_sel[k]);
        tick(1);
      end
      check("rx_len", 64'(h), 64'(rx_len[k]));
    end

    // Retrigger two cycles after the first extends the pulse to six cycles
    send_rx(CMD_TRIG1);
    h = sample(2);
    tick(1);
    h += sample(2);
    send_rx(CMD_TRIG1);
    for (int j = 0; j < 10; j++) begin
      h += sample(2);
      tick(1);
    end
    check("retrig_len", 64'(h), 64'd6);

    // Reset after the third byte with ready held high: full resend afterwards
    {i1CounterHi, i1Counter} = 64'h0000_00AB_CDEF_0123;
    push_packet(HDR_REG1, 64'h0000_00AB_CDEF_0123);
    log_b.delete(); log_c.delete();
    iRdy1 = 1'b1;
    for (int i = 0; i < 50 && log_b.size() < 3; i++) tick(1);
    check("rst_mid_reached", 64'(log_b.size()), 64'd3);
    iRST = 1'b1;
    #1;
    check("rst_mid_valid", 64'(oTxValid), 64'd0);
    check("rst_mid_busy", 64'(oBusy), 64'd0);
    check("rst_mid_data", 64'(oTxData), 64'd0);
    exp_q.delete();
    tick(2);
    iRST = 1'b0;
    push_packet(HDR_REG1, 64'h0000_00AB_CDEF_0123);
    log_b.delete(); log_c.delete();
    wait_tx_done("resend_done", 50);
    tick(10);
    check("resend_len", 64'(log_b.size()), 64'd6);
    if (log_b.size() >= 2) begin
      check("resend_hdr", 64'(log_b[0]), 64'h00);
      check("resend_b0", 64'(log_b[1]), 64'h23);
    end
    iRdy1 = 1'b0;
    tick(5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_link.md
Name: counter_link

Overview:
- Host-side link engine for the two-register latch counter.
- Reads latched counter values and their ready flags, and serialises each into a framed byte packet on a byte-stream transmit interface (USB FIFO / UART TX).
- Decodes host command bytes from a byte-stream receive interface into latch-reset and test-latch strobes back to the counter.
- Sits between the counter block and the USB byte bridge.

Parameters:
- pBYTES, 5, number of counter bytes sent per packet, LSB first; legal range 1..8.
- pPULSE, 4, width in iCLK cycles of the oLatch1/oLatch2 test pulses; legal range 1..255.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  asynchronous, active-high reset.
- iRdy1  in  1  register 1 latched flag (asynchronous to iCLK).
- i1Counter  in  32  register 1, low word.
- i1CounterHi  in  32  register 1, high word.
- iRdy2  in  1  register 2 latched flag (asynchronous to iCLK).
- i2Counter  in  32  register 2, low word.
- i2CounterHi  in  32  register 2, high word.
- oResetLatch1  out  1  one-cycle strobe; clears register 1 latch.
- oResetLatch2  out  1  one-cycle strobe; clears register 2 latch.
- oLatch1  out  1  pPULSE-cycle test latch request for register 1.
- oLatch2  out  1  pPULSE-cycle test latch request for register 2.
- oTxData  out  8  transmit byte.
- oTxValid  out  1  transmit byte valid.
- iTxReady  in  1  sink accepts; a byte transfers when oTxValid and iTxReady are both high.
- iRxData  in  8  received byte.
- iRxValid  in  1  one-cycle receive strobe; no backpressure.
- oBadCmd  out  1  one-cycle strobe on an unrecognised command byte.
- oBusy  out  1  transmit FSM not in IDLE.

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM goes to IDLE.
  - sent1, sent2, pulse counters and the shift register are cleared.
- Synchronisation:
  - iRdy1 and iRdy2 each pass through a 2-flop synchroniser; rdyN_s is the synchronised value.
  - Counter data is sampled only while rdyN_s=1. The data is stable because the counter holds it while latched.
- Packet format: header byte, then pBYTES bytes of {iNCounterHi, iNCounter}[8*pBYTES-1:0], LSB first.
  - Header 0x00 for register 1, 0x01 for register 2.
- TX FSM states: IDLE, HDR, DATA.
  - IDLE: if rdy1_s && !sent1, select reg 1; else if rdy2_s && !sent2, select reg 2.
    - On selection, snapshot the 64-bit value into the shift register, set byte count to pBYTES, and go to HDR.
    - oTxValid rises the cycle after selection.
  - HDR: drive the header; on handshake go to DATA.
  - DATA: drive shift[7:0]; on handshake shift right 8 bits and decrement the count.
    - After the last byte, set sentN and return to IDLE.
    - A new packet may start on the next cycle.
  - oTxData/oTxValid hold constant while iTxReady=0 (AXI-stream style; valid never drops without a handshake).
- sentN clears when rdyN_s is low. Each latch event is therefore sent exactly once, regardless of ack timing.
- Priority: register 1 wins over register 2 when both are pending. Register 2 is sent in the following packet.
- RX decode, one cycle of latency (byte at cycle N produces output at N+1):
  - 0x00: pulse oResetLatch1.
  - 0x01: pulse oResetLatch2.
  - 0x02: start the oLatch1 pulse.
  - 0x03: start the oLatch2 pulse.
  - Any other byte: pulse oBadCmd with no other effect.
- Acks (0x00/0x01) pulse unconditionally, even if no packet was sent.
- RX decoding is independent of TX state; commands received mid-packet act immediately.
- Test-latch pulses: oLatchN stays high exactly pPULSE cycles.
  - A repeat 0x02/0x03 during an active pulse reloads the counter, extending the pulse to pPULSE cycles from the new byte.
- Snapshot isolation: if rdyN_s drops or the counter data changes mid-packet, the in-flight packet is unaffected.
  - sentN still sets at the end of the packet, then clears the next cycle if rdyN_s is low.
- Reset mid-packet: the packet is abandoned with no partial completion. After reset release, a still-high rdyN_s causes a full resend.

Decomposition:
- Package counter_link_pkg:
  - Command constants: CMD_ACK1=8'h00, CMD_ACK2=8'h01, CMD_TRIG1=8'h02, CMD_TRIG2=8'h03.
  - Header constants: HDR_REG1=8'h00, HDR_REG2=8'h01.
  - FSM state enum.
- Sub-module sync_2ff: generic single-bit 2-flop synchroniser with async reset. Instantiated twice.

Test Plan:
- iRdy1 rises with {Hi,Lo}=64'h0000_0012_3456_789A, iTxReady=1 -> TX sequence 00 9A 78 56 34 12, six consecutive cycles, no repeat while iRdy1 stays high.
- iRdy1 and iRdy2 rise in the same cycle (reg2 value 64'h55) -> packet 00+reg1 first, then 01 55 00 00 00 00.
- iTxReady toggled 1-0-0-1 per cycle during a packet -> byte order and values unchanged; oTxData/oTxValid stable during stalls.
- RX bytes 00, 01, 02, 07 on separate strobes -> oResetLatch1 for 1 cycle, oResetLatch2 for 1 cycle, oLatch1 high 4 cycles, oBadCmd for 1 cycle.
- 0x02 received, then 0x02 again 2 cycles later -> oLatch1 high for 6 cycles total.
- iRST asserted after the 3rd byte with iRdy1 held high -> outputs 0 immediately; after release, full packet 00 + 5 bytes resent.
